// File: rtl/video_pkg.sv
`default_nettype none
// ============================================================================
// Module   : video_pkg
// Brief    : Shared types and constants for the LCD video path and its checker.
// Revision : 1.0
// ============================================================================
package video_pkg;

    typedef enum logic [0:0] {
        WAIT_VS = 1'b0,
        ACTIVE  = 1'b1
    } vt_state_t;

    // CRC-16-CCITT, MSB first, no reflection
    localparam logic [15:0] c_crc_poly = 16'h1021;
    localparam logic [15:0] c_crc_init = 16'hFFFF;

    localparam int c_def_h_active = 800;
    localparam int c_def_v_active = 480;

endpackage
`default_nettype wire

// File: rtl/crc16_24b.sv
`default_nettype none
// ============================================================================
// Module   : crc16_24b
// Brief    : Single-cycle CRC-16 update over one 24-bit word, MSB first.
// Revision : 1.0
// ============================================================================
module crc16_24b
    import video_pkg::*;
(
    input  logic [15:0] i_crc,
    input  logic [23:0] i_data,
    output logic [15:0] o_crc
);

    logic [15:0] w_acc;

    always_comb begin
        w_acc = i_crc;
        for (int i = 23; i >= 0; i--) begin
            if (w_acc[15] ^ i_data[i]) begin
                w_acc = {w_acc[14:0], 1'b0} ^ c_crc_poly;
            end else begin
                w_acc = {w_acc[14:0], 1'b0};
            end
        end
        o_crc = w_acc;
    end

endmodule
`default_nettype wire

// File: rtl/video_timing_checker.sv
`default_nettype none
// ============================================================================
// Module   : video_timing_checker
// Brief    : Passive LCD-interface monitor measuring active width/height per
//            frame, with lock tracking. Define VIDEO_CRC_EN to add a per-frame
//            CRC-16 of active pixels on frame_crc (tied to 0 otherwise).
// Revision : 1.0
// ============================================================================
module video_timing_checker
    import video_pkg::*;
#(
    parameter int H_ACTIVE = c_def_h_active,
    parameter int V_ACTIVE = c_def_v_active,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hs,
    input  logic             vs,
    input  logic             de,
    input  logic [7:0]       rgb_r,
    input  logic [7:0]       rgb_g,
    input  logic [7:0]       rgb_b,
    output logic             frame_done,
    output logic [CNT_W-1:0] meas_width,
    output logic [CNT_W-1:0] meas_height,
    output logic             err_width,
    output logic             err_height,
    output logic             locked,
    output logic [15:0]      frame_cnt,
    output logic [15:0]      frame_crc
);

    localparam logic [CNT_W-1:0] c_h_active = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] c_v_active = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_one      = CNT_W'(1);

    logic r_s1_vs, r_s1_de, r_s2_vs, r_s2_de;
    logic r_ev_vs, r_ev_rise, r_ev_fall;

    // Events are registered so they line up with the s2 pixel data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_vs   <= VS_POL;
            r_s2_vs   <= VS_POL;
            r_s1_de   <= 1'b0;
            r_s2_de   <= 1'b0;
            r_ev_vs   <= 1'b0;
            r_ev_rise <= 1'b0;
            r_ev_fall <= 1'b0;
        end else begin
            r_s1_vs   <= vs;
            r_s1_de   <= de;
            r_s2_vs   <= r_s1_vs;
            r_s2_de   <= r_s1_de;
            r_ev_vs   <= (r_s1_vs == VS_POL) && (r_s2_vs != VS_POL);
            r_ev_rise <= r_s1_de && !r_s2_de;
            r_ev_fall <= !r_s1_de && r_s2_de;
        end
    end

    vt_state_t        r_state;
    logic [CNT_W-1:0] r_pix;
    logic [CNT_W-1:0] r_lines;
    logic [CNT_W-1:0] r_width;
    logic             r_err;
    logic             r_line_open;
    logic [1:0]       r_good_cnt;

    logic             w_line_closed;
    logic             w_eval;
    logic             w_err_next;
    logic             w_good;
    logic [CNT_W-1:0] w_lines_next;
    logic [CNT_W-1:0] w_width_next;

    // A line closing in the vs-start cycle still belongs to the ending frame
    always_comb begin
        w_line_closed = r_ev_fall && r_line_open;
        w_eval        = r_ev_vs && (r_state == ACTIVE);
        w_lines_next  = r_lines;
        if (w_line_closed && (r_lines != c_cnt_max)) begin
            w_lines_next = r_lines + c_one;
        end
        w_err_next   = r_err || (w_line_closed && (r_pix != c_h_active));
        w_width_next = (w_line_closed && !r_err) ? r_pix : r_width;
        w_good       = !w_err_next && (w_lines_next == c_v_active);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= WAIT_VS;
            r_pix       <= '0;
            r_lines     <= '0;
            r_width     <= '0;
            r_err       <= 1'b0;
            r_line_open <= 1'b0;
            r_good_cnt  <= 2'd0;
            frame_done  <= 1'b0;
            meas_width  <= '0;
            meas_height <= '0;
            err_width   <= 1'b0;
            err_height  <= 1'b0;
            locked      <= 1'b0;
            frame_cnt   <= 16'd0;
        end else begin
            frame_done <= 1'b0;

            if (r_ev_rise) begin
                r_pix <= c_one;
            end else if (r_s2_de && (r_pix != c_cnt_max)) begin
                r_pix <= r_pix + c_one;
            end

            // A line still open at vs-start is dropped, not carried over
            if (r_ev_rise) begin
                r_line_open <= 1'b1;
            end else if (r_ev_vs || r_ev_fall) begin
                r_line_open <= 1'b0;
            end

            if (r_ev_vs) begin
                r_state <= ACTIVE;
                r_lines <= '0;
                r_err   <= 1'b0;
                r_width <= '0;
            end else begin
                r_lines <= w_lines_next;
                r_err   <= w_err_next;
                r_width <= w_width_next;
            end

            if (w_eval) begin
                frame_done  <= 1'b1;
                meas_height <= w_lines_next;
                err_height  <= (w_lines_next != c_v_active);
                err_width   <= w_err_next;
                if (w_lines_next != '0) begin
                    meas_width <= w_width_next;
                end
                frame_cnt <= frame_cnt + 16'd1;
                if (w_good) begin
                    locked <= (r_good_cnt != 2'd0);
                    if (r_good_cnt != 2'd2) begin
                        r_good_cnt <= r_good_cnt + 2'd1;
                    end
                end else begin
                    locked     <= 1'b0;
                    r_good_cnt <= 2'd0;
                end
            end
        end
    end

`ifdef VIDEO_CRC_EN
    logic [23:0] r_s1_rgb, r_s2_rgb;
    logic [15:0] r_crc, r_frame_crc, w_crc_upd, w_crc_next;

    crc16_24b u_crc16 (
        .i_crc  (r_crc),
        .i_data (r_s2_rgb),
        .o_crc  (w_crc_upd)
    );

    assign w_crc_next = r_s2_de ? w_crc_upd : r_crc;
    assign frame_crc  = r_frame_crc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_rgb    <= 24'd0;
            r_s2_rgb    <= 24'd0;
            r_crc       <= c_crc_init;
            r_frame_crc <= 16'd0;
        end else begin
            r_s1_rgb <= {rgb_r, rgb_g, rgb_b};
            r_s2_rgb <= r_s1_rgb;
            r_crc    <= r_ev_vs ? c_crc_init : w_crc_next;
            if (w_eval) begin
                r_frame_crc <= w_crc_next;
            end
        end
    end

    logic w_unused;
    assign w_unused = hs;
`else
    assign frame_crc = 16'h0000;

    logic w_unused;
    assign w_unused = ^{hs, rgb_r, rgb_g, rgb_b};
`endif

endmodule
`default_nettype wire
